riscv_data_mem: RTL and testbench

- Data-side responder for the single-cycle RISC-V core. It answers the core's data interface: MemWrite, Mem_WrAddr, Mem_WrData and funct3 in; ReadData out.
- Contains word-organised data RAM with byte/halfword/word load formatting and store merging, plus a small MMIO block: 64-bit cycle timer, compare interrupt and LED register.
- Sits beside the core at top level; the core's load path consumes ReadData in the same cycle.

---
 rtl/riscv_data_mem.sv | 156 +++++++++++++++
 tb/tb_riscv_data_mem.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem.sv
// Data-side responder for the single-cycle RISC-V core.
// Word RAM with sized load/store formatting plus timer/LED MMIO window.
module riscv_data_mem #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        misaligned,
    output logic [7:0]  led,
    output logic        timer_irq
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] A_LO      = MMIO_BASE;
    localparam logic [31:0] A_HI      = MMIO_BASE + 32'd4;
    localparam logic [31:0] A_CMP     = MMIO_BASE + 32'd8;
    localparam logic [31:0] A_STAT    = MMIO_BASE + 32'd12;
    localparam logic [31:0] A_LED     = MMIO_BASE + 32'd16;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [63:0]   r_mtime;
    logic [31:0]   r_mtimecmp;
    logic [7:0]    r_led;
    logic          r_irq;

    logic          w_is_ram;
    logic [AW-1:0] w_ram_idx;
    logic          w_sel_lo;
    logic          w_sel_hi;
    logic          w_sel_cmp;
    logic          w_sel_stat;
    logic          w_sel_led;
    logic          w_is_half;
    logic          w_is_word;
    logic          w_store;
    logic          w_mmio_we;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;

    assign w_is_ram   = Mem_WrAddr < RAM_BYTES;
    assign w_ram_idx  = Mem_WrAddr[AW+1:2];
    assign w_sel_lo   = Mem_WrAddr[31:2] == A_LO[31:2];
    assign w_sel_hi   = Mem_WrAddr[31:2] == A_HI[31:2];
    assign w_sel_cmp  = Mem_WrAddr[31:2] == A_CMP[31:2];
    assign w_sel_stat = Mem_WrAddr[31:2] == A_STAT[31:2];
    assign w_sel_led  = Mem_WrAddr[31:2] == A_LED[31:2];

    assign w_is_half  = funct3[1:0] == 2'b01;
    assign w_is_word  = funct3 == 3'b010;
    assign misaligned = (w_is_half && Mem_WrAddr[0])
                     || (w_is_word && (Mem_WrAddr[1:0] != 2'b00));

    // Stores presented while reset is held are dropped.
    assign w_store   = MemWrite && !misaligned && !reset;
    assign w_mmio_we = w_store && w_is_word;

    always_comb begin
        w_word = '0;
        if (w_is_ram)        w_word = r_mem[w_ram_idx];
        else if (w_sel_lo)   w_word = r_mtime[31:0];
        else if (w_sel_hi)   w_word = r_mtime[63:32];
        else if (w_sel_cmp)  w_word = r_mtimecmp;
        else if (w_sel_stat) w_word = {31'd0, r_irq};
        else if (w_sel_led)  w_word = {24'd0, r_led};
    end

    always_comb begin
        w_byte = w_word[7:0];
        case (Mem_WrAddr[1:0])
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign w_half = Mem_WrAddr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        ReadData = '0;
        if (!misaligned) begin
            case (funct3)
                3'b000:  ReadData = {{24{w_byte[7]}}, w_byte};
                3'b001:  ReadData = {{16{w_half[15]}}, w_half};
                3'b010:  ReadData = w_word;
                3'b100:  ReadData = {24'd0, w_byte};
                3'b101:  ReadData = {16'd0, w_half};
                default: ReadData = '0;
            endcase
        end
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = Mem_WrData;
        case (funct3)
            3'b000: begin
                w_be    = 4'b0001 << Mem_WrAddr[1:0];
                w_wdata = {4{Mem_WrData[7:0]}};
            end
            3'b001: begin
                w_be    = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{Mem_WrData[15:0]}};
            end
            3'b010: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store && w_is_ram) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_ram_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= 32'hFFFF_FFFF;
            r_led      <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_mmio_we && w_sel_lo)
                r_mtime <= {r_mtime[63:32], Mem_WrData};
            else if (w_mmio_we && w_sel_hi)
                r_mtime <= {Mem_WrData, r_mtime[31:0]};
            else
                r_mtime <= r_mtime + 64'd1;

            if (w_mmio_we && w_sel_cmp) r_mtimecmp <= Mem_WrData;
            if (w_mmio_we && w_sel_led) r_led      <= Mem_WrData[7:0];

            // A compare match outranks a simultaneous W1C.
            if (r_mtime[31:0] == r_mtimecmp)
                r_irq <= 1'b1;
            else if (w_mmio_we && w_sel_stat && Mem_WrData[0])
                r_irq <= 1'b0;
        end
    end

    assign led       = r_led;
    assign timer_irq = r_irq;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed self-checking bench for riscv_data_mem.
// RAM formatting, misalignment, timer, IRQ, LED and reset behaviour.
module tb_riscv_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;
    logic        misaligned;
    logic [7:0]  led;
    logic        timer_irq;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
    localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;
    localparam logic [31:0] MB = 32'h0000_0400;

    riscv_data_mem dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .ReadData   (ReadData),
        .misaligned (misaligned),
        .led        (led),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d);
        MemWrite   = 1'b1;
        funct3     = f3;
        Mem_WrAddr = a;
        Mem_WrData = d;
        tick();
        MemWrite   = 1'b0;
    endtask

    task automatic ld(input string tag, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] exp);
        MemWrite   = 1'b0;
        funct3     = f3;
        Mem_WrAddr = a;
        #1;
        chk(tag, ReadData, exp);
    endtask

    initial begin
        reset      = 1'b1;
        MemWrite   = 1'b0;
        funct3     = 3'b000;
        Mem_WrAddr = '0;
        Mem_WrData = '0;
        tick();
        tick();
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        ld("rst_mtime", LW, MB, 32'h0);
        ld("rst_cmp", LW, MB + 32'h8, 32'hFFFF_FFFF);

        reset = 1'b0;
        repeat (10) tick();
        ld("mtime10", LW, MB, 32'd10);
        ld("mtimehi0", LW, MB + 32'h4, 32'd0);

        st(LW, MB, 32'hFFFF_FFFF);
        ld("lo_wr", LW, MB, 32'hFFFF_FFFF);
        tick();
        ld("lo_wrap", LW, MB, 32'h0);
        ld("hi_carry", LW, MB + 32'h4, 32'h1);
        chk("irq_ffff", 32'(timer_irq), 32'h1);
        ld("status1", LW, MB + 32'hC, 32'h1);
        st(LW, MB + 32'hC, 32'h1);
        chk("irq_clr", 32'(timer_irq), 32'h0);

        st(LW, 32'h10, 32'h8899_AABB);
        ld("lw10", LW, 32'h10, 32'h8899_AABB);
        ld("lb10", LB, 32'h10, 32'hFFFF_FFBB);
        ld("lb11", LB, 32'h11, 32'hFFFF_FFAA);
        ld("lbu12", LBU, 32'h12, 32'h0000_0099);
        ld("lbu13", LBU, 32'h13, 32'h0000_0088);
        ld("lh12", LH, 32'h12, 32'hFFFF_8899);
        chk("lh12_mis", 32'(misaligned), 32'h0);
        ld("lhu10", LHU, 32'h10, 32'h0000_AABB);
        ld("f3_011", 3'b011, 32'h10, 32'h0);

        st(LW, 32'h20, 32'h0);
        st(LB, 32'h21, 32'hFFFF_FF12);
        st(LH, 32'h22, 32'h1234_BEEF);
        ld("merge", LW, 32'h20, 32'hBEEF_1200);

        st(LW, 32'h30, 32'h0123_4567);
        MemWrite = 1'b1; funct3 = LH; Mem_WrAddr = 32'h31;
        Mem_WrData = 32'hFFFF_FFFF;
        #1;
        chk("sh31_mis", 32'(misaligned), 32'h1);
        tick();
        funct3 = LW; Mem_WrAddr = 32'h32;
        #1;
        chk("sw32_mis", 32'(misaligned), 32'h1);
        tick();
        MemWrite = 1'b0;
        ld("lw30_keep", LW, 32'h30, 32'h0123_4567);
        ld("lw32_zero", LW, 32'h32, 32'h0);
        chk("lw32_mis", 32'(misaligned), 32'h1);

        st(LW, MB, 32'd100);
        st(LW, MB + 32'h8, 32'd105);
        repeat (4) tick();
        chk("irq_early", 32'(timer_irq), 32'h0);
        tick();
        chk("irq_set", 32'(timer_irq), 32'h1);
        tick();
        chk("irq_sticky", 32'(timer_irq), 32'h1);
        st(LW, MB, 32'd200);
        st(LW, MB + 32'hC, 32'h1);
        chk("irq_w1c", 32'(timer_irq), 32'h0);
        st(LW, MB + 32'h8, 32'd203);
        tick();
        chk("irq_pre", 32'(timer_irq), 32'h0);
        st(LW, MB + 32'hC, 32'h1);
        chk("irq_setwins", 32'(timer_irq), 32'h1);

        st(LW, MB + 32'h10, 32'h0000_01A5);
        chk("led_sw", 32'(led), 32'h0000_00A5);
        ld("led_rd", LW, MB + 32'h10, 32'h0000_00A5);
        st(LB, MB + 32'h10, 32'h0000_0000);
        chk("led_sb", 32'(led), 32'h0000_00A5);
        st(LW, 32'h2000, 32'hDEAD_BEEF);
        ld("unmapped", LW, 32'h2000, 32'h0);
        ld("unmap414", LW, MB + 32'h14, 32'h0);

        st(LW, 32'h40, 32'hCAFE_F00D);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_led", 32'(led), 32'h0);
        chk("mid_irq", 32'(timer_irq), 32'h0);
        ld("mid_mtime", LW, MB, 32'h0);
        st(LW, 32'h40, 32'h1111_1111);
        reset = 1'b0;
        ld("rst_store", LW, 32'h40, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
